// File: rtl/magnitude_comparator_if.sv
// magnitude_comparator_if: operand stream (in_valid/is_signed/A/B/cnt_clr) in, registered flags (out_valid/equal/A_more_B/A_less_B) and outcome counters out
interface magnitude_comparator_if #(
  parameter int K = 4,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic is_signed;
  logic [K-1:0] A;
  logic [K-1:0] B;
  logic cnt_clr;
  logic out_valid;
  logic equal;
  logic A_more_B;
  logic A_less_B;
  logic [CNT_W-1:0] eq_count;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] lt_count;
  modport master (
    output in_valid, is_signed, A, B, cnt_clr,
    input out_valid, equal, A_more_B, A_less_B, eq_count, gt_count, lt_count
  );
  modport slave (
    input in_valid, is_signed, A, B, cnt_clr,
    output out_valid, equal, A_more_B, A_less_B, eq_count, gt_count, lt_count
  );
endinterface

// File: rtl/magnitude_comparator.sv
// magnitude_comparator: registered signed/unsigned K-bit compare with saturating eq/gt/lt counters; ports clk, rst (sync, active-high), bus (slave side of magnitude_comparator_if)
module magnitude_comparator #(
  parameter int K = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  magnitude_comparator_if.slave bus
);
  logic eq, gt, lt;
  always_comb begin
    eq = bus.A == bus.B;
    gt = bus.is_signed ? ($signed(bus.A) > $signed(bus.B)) : (bus.A > bus.B);
    lt = !eq && !gt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.equal <= 1'b0;
      bus.A_more_B <= 1'b0;
      bus.A_less_B <= 1'b0;
      bus.eq_count <= '0;
      bus.gt_count <= '0;
      bus.lt_count <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.equal <= eq;
        bus.A_more_B <= gt;
        bus.A_less_B <= lt;
      end
      if (bus.cnt_clr) begin
        bus.eq_count <= '0;
        bus.gt_count <= '0;
        bus.lt_count <= '0;
      end else if (bus.in_valid) begin
        if (eq && ~&bus.eq_count) bus.eq_count <= bus.eq_count + CNT_W'(1);
        if (gt && ~&bus.gt_count) bus.gt_count <= bus.gt_count + CNT_W'(1);
        if (lt && ~&bus.lt_count) bus.lt_count <= bus.lt_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_magnitude_comparator.sv
// tb_magnitude_comparator: directed and random checks of magnitude_comparator (K=4, CNT_W=2)
module tb_magnitude_comparator;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  magnitude_comparator_if #(.K(4), .CNT_W(2)) bus ();
  magnitude_comparator #(.K(4), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [3:0] fl();
    return {bus.out_valid, bus.equal, bus.A_more_B, bus.A_less_B};
  endfunction
  function automatic logic [5:0] cn();
    return {bus.eq_count, bus.gt_count, bus.lt_count};
  endfunction
  task automatic drive(input logic v, input logic s, input logic [3:0] a, input logic [3:0] b, input logic c);
    bus.in_valid = v;
    bus.is_signed = s;
    bus.A = a;
    bus.B = b;
    bus.cnt_clr = c;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 4'd5, 4'd5, 0);
    tick();
    tick();
    checks++;
    if ({fl(), cn()} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {fl(), cn()}, 10'd0);
    end
    rst = 1'b0;
    drive(0, 0, 4'd5, 4'd5, 0);
    tick();
    checks++;
    if ({fl(), cn()} !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=%b", {fl(), cn()}, 10'd0);
    end
  endtask
  task automatic test_unsigned();
    logic [3:0] a[3] = '{4'd5, 4'd9, 4'd2};
    logic [3:0] b[3] = '{4'd5, 4'd3, 4'd14};
    logic [3:0] e[3] = '{4'b1100, 4'b1010, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, a[i], b[i], 0);
      tick();
      checks++;
      if (fl() !== e[i]) begin
        errors++;
        $display("FAIL unsigned_flags[%0d] got=%b exp=%b", i, fl(), e[i]);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++;
    if ({fl(), cn()} !== 10'b0001_01_01_01) begin
      errors++;
      $display("FAIL unsigned_counts got=%b exp=%b", {fl(), cn()}, 10'b0001_01_01_01);
    end
  endtask
  task automatic test_signed();
    logic [3:0] a[4] = '{4'b1000, 4'b1000, 4'b1111, 4'b1111};
    logic [3:0] b[4] = '{4'b0111, 4'b0111, 4'b1111, 4'b1111};
    logic s[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] e[4] = '{4'b1001, 4'b1010, 4'b1100, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      drive(1, s[i], a[i], b[i], 0);
      tick();
      checks++;
      if (fl() !== e[i]) begin
        errors++;
        $display("FAIL signed_flags[%0d] got=%b exp=%b", i, fl(), e[i]);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++;
    if (cn() !== 6'b11_10_10) begin
      errors++;
      $display("FAIL signed_counts got=%b exp=%b", cn(), 6'b11_10_10);
    end
  endtask
  task automatic test_hold();
    drive(1, 0, 4'd9, 4'd3, 0);
    tick();
    checks++;
    if ({fl(), cn()} !== 10'b1010_11_11_10) begin
      errors++;
      $display("FAIL hold_sample got=%b exp=%b", {fl(), cn()}, 10'b1010_11_11_10);
    end
    drive(0, 1, 4'd1, 4'd9, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({fl(), cn()} !== 10'b0010_11_11_10) begin
        errors++;
        $display("FAIL hold_idle[%0d] got=%b exp=%b", i, {fl(), cn()}, 10'b0010_11_11_10);
      end
    end
  endtask
  task automatic test_saturation();
    drive(0, 0, 0, 0, 1);
    tick();
    checks++;
    if ({fl(), cn()} !== 10'b0010_00_00_00) begin
      errors++;
      $display("FAIL clear_idle got=%b exp=%b", {fl(), cn()}, 10'b0010_00_00_00);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4'd6, 4'd6, 0);
      tick();
      checks++;
      if (bus.eq_count !== ((i < 2) ? 2'(i + 1) : 2'd3)) begin
        errors++;
        $display("FAIL sat_eq_count[%0d] got=%0d exp=%0d", i, bus.eq_count, (i < 2) ? i + 1 : 3);
      end
    end
    drive(1, 0, 4'd1, 4'd1, 1);
    tick();
    checks++;
    if ({fl(), cn()} !== 10'b1100_00_00_00) begin
      errors++;
      $display("FAIL clear_with_valid got=%b exp=%b", {fl(), cn()}, 10'b1100_00_00_00);
    end
  endtask
  task automatic test_random();
    logic [2:0] ef = 3'b100;
    int ec = 0, gc = 0, lc = 0;
    for (int i = 0; i < 40; i++) begin
      logic v, s, c;
      logic [3:0] a, b;
      int ia, ib;
      v = $urandom_range(0, 3) != 0;
      s = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 11) == 0;
      a = 4'($urandom_range(0, 15));
      b = (i % 5 == 0) ? a : 4'($urandom_range(0, 15));
      drive(v, s, a, b, c);
      tick();
      ia = (s && a[3]) ? int'(a) - 16 : int'(a);
      ib = (s && b[3]) ? int'(b) - 16 : int'(b);
      if (v) ef = {ia == ib, ia > ib, ia < ib};
      if (c) begin
        ec = 0;
        gc = 0;
        lc = 0;
      end else if (v) begin
        if (ia == ib && ec < 3) ec++;
        if (ia > ib && gc < 3) gc++;
        if (ia < ib && lc < 3) lc++;
      end
      checks++;
      if ({fl(), cn()} !== {v, ef, 2'(ec), 2'(gc), 2'(lc)}) begin
        errors++;
        $display("FAIL random[%0d] got=%b exp=%b", i, {fl(), cn()}, {v, ef, 2'(ec), 2'(gc), 2'(lc)});
      end
      checks++;
      if ($countones(fl()) - 32'(bus.out_valid) != 1) begin
        errors++;
        $display("FAIL random_onehot[%0d] got=%b exp=one-hot", i, fl());
      end
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_hold();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
